// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier owning the HI/LO product registers.
// Runs a fixed WIDTH-iteration loop on operand magnitudes, then sign-corrects into HI/LO.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multstartE,
  input  logic             multsgnE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hilouseD,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             multstallD
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       count;
  logic                   neg;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic [2*WIDTH-1:0]     acc;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     result;

  // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which is representable unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] nv;
    nv = -v;
    if (sgn && v[WIDTH-1]) return $unsigned(nv);
    return $unsigned(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic n);
    logic signed [2*WIDTH-1:0] sp;
    sp = $signed(p);
    if (n) return $unsigned(-sp);
    return p;
  endfunction

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    result = apply_sign(acc, neg);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (multstartE) state_nxt = RUN;
      RUN:  if (count == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign multstallD = hilouseD & (busy | multstartE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control and architectural registers; in-flight work is dropped on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: if (multstartE) begin
          count <= '0;
          neg   <= multsgnE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        end
        RUN: count <= count + CNT_W'(1);
        FIX: {hi, lo} <= result;
        default: ;
      endcase
    end
  end

  // Datapath: carry out of the WIDTH+1 bit adder shifts into the accumulator MSB.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: if (multstartE && !reset) begin
        mcand  <= magnitude($signed(srcaE), multsgnE);
        mplier <= magnitude($signed(srcbE), multsgnE);
        acc    <= '0;
      end
      RUN: begin
        acc    <= {sum, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: cycle-level reference model plus directed product vectors.
module tb_mult_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         multstartE = 1'b0;
  logic         multsgnE = 1'b0;
  logic         hilouseD = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, multstallD;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .multstartE(multstartE), .multsgnE(multsgnE),
    .srcaE(srcaE), .srcbE(srcbE), .hilouseD(hilouseD),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .multstallD(multstallD)
  );

  // Reference: full product by plain arithmetic, published 33 edges after acceptance.
  logic [2*W-1:0] m_prod = '0;
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  logic           m_busy = 1'b0, m_done = 1'b0;
  int             m_left = 0;

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sgn);
    logic [2*W-1:0] ea, eb;
    ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_prod;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (multstartE) begin
        m_prod <= ref_product(srcaE, srcbE, multsgnE);
        m_left <= 33;
        m_busy <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_hi",    64'(hi),         64'(m_hi));
      chk("model_lo",    64'(lo),         64'(m_lo));
      chk("model_busy",  64'(busy),       64'(m_busy));
      chk("model_done",  64'(done),       64'(m_done));
      chk("model_stall", 64'(multstallD), 64'(hilouseD & (m_busy | multstartE)));
    end
  end

  // Issues one multiply and waits (bounded) for done; k counts edges from E0 inclusive.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic use_hl, input int inj_at, input bit immediate,
                          output int k, output int stalls);
    bit got;
    if (immediate) #1;
    else begin
      @(posedge clk); #1;
    end
    multstartE = 1'b1; multsgnE = sgn; srcaE = a; srcbE = b; hilouseD = use_hl;
    k = 0; got = 1'b0; stalls = 0;
    if (!immediate) begin
      @(negedge clk);
      if (multstallD) stalls++;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      k++;
      #1;
      multstartE = (k == inj_at);
      if (k == inj_at) begin
        srcaE = 32'd2; srcbE = 32'd2;
      end
      @(negedge clk);
      if (multstallD) stalls++;
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 64'(got), 64'(1));
  endtask

  int k, st, pulses;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0, k, st);
    chk("umax_latency", 64'(k), 64'(34));
    chk("umax_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("umax_lo", 64'(lo), 64'h0000_0001);
    chk("umax_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("umax_done_one_cycle", 64'(done), 64'(0));

    run_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, -1, 1'b0, k, st);
    chk("smix_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("smix_lo", 64'(lo), 64'hFFFF_FFF1);
    run_mult(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, -1, 1'b0, k, st);
    chk("umix_hi", 64'(hi), 64'h0000_0004);
    chk("umix_lo", 64'(lo), 64'hFFFF_FFF1);

    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, -1, 1'b0, k, st);
    chk("scorner_hi", 64'(hi), 64'h4000_0000);
    chk("scorner_lo", 64'(lo), 64'h0);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, 1'b1, k, st);
    chk("b2b_latency", 64'(k), 64'(34));
    chk("b2b_hi", 64'(hi), 64'h0);
    chk("b2b_lo", 64'(lo), 64'h1);

    run_mult(32'd3, 32'd4, 1'b0, 1'b1, -1, 1'b0, k, st);
    chk("stall_cycles", 64'(st), 64'(34));
    chk("stall_released", 64'(multstallD), 64'(0));
    chk("stall_lo", 64'(lo), 64'd12);
    hilouseD = 1'b0;
    run_mult(32'd5, 32'd6, 1'b0, 1'b0, -1, 1'b0, k, st);
    chk("nostall_cycles", 64'(st), 64'(0));
    chk("nostall_lo", 64'(lo), 64'd30);

    run_mult(32'd7, 32'd6, 1'b0, 1'b0, 10, 1'b0, k, st);
    chk("busystart_latency", 64'(k), 64'(34));
    chk("busystart_hi", 64'(hi), 64'h0);
    chk("busystart_lo", 64'(lo), 64'd42);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("busystart_no_second_done", 64'(pulses), 64'(0));

    @(posedge clk); #1;
    multstartE = 1'b1; multsgnE = 1'b0; srcaE = 32'd9; srcbE = 32'd9;
    @(posedge clk); #1;
    multstartE = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1; multstartE = 1'b1;
    @(negedge clk);
    chk("rst_stall_during", 64'(multstallD), 64'(0));
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    #1 reset = 1'b0; multstartE = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_no_done", 64'(pulses), 64'(0));
    chk("rst_idle_busy", 64'(busy), 64'(0));
    run_mult(32'd7, 32'd6, 1'b0, 1'b0, -1, 1'b0, k, st);
    chk("rst_fresh_hi", 64'(hi), 64'h0);
    chk("rst_fresh_lo", 64'(lo), 64'd42);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative multiply sequencer that owns the HI/LO product registers for the pipelined MIPS core. It accepts `mult`/`multu` issued from Execute and runs a fixed-latency radix-2 shift-add over 32 cycles with sign correction. It tells the hazard logic to stall Decode whenever a HI/LO consumer (`mfhi`, `mflo`) or another multiply would see an unfinished result. HI/LO feed the writeback select (`wbsrc` = HI/LO paths).

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; iteration count = `WIDTH`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `multstartE`  in  1  multiply in Execute this cycle; sampled only in IDLE.
- `multsgnE`  in  1  1 = signed (`mult`), 0 = unsigned (`multu`).
- `srcaE`, `srcbE`  in  WIDTH  forwarded operands from Execute.
- `hilouseD`  in  1  Decode holds `mfhi`, `mflo`, `mult` or `multu`.
- `hi`, `lo`  out  WIDTH  architectural product registers.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse, high in the cycle after HI/LO update.
- `multstallD`  out  1  stall request to hazard unit.

## Operation
- State machine: IDLE, RUN, FIX.
  - IDLE, `multstartE`=1: latch operand magnitudes. If `multsgnE`=1, take the absolute value of each; `neg` = sign(a) XOR sign(b). Otherwise use raw operands and `neg`=0. Clear the 2·WIDTH accumulator, set `count`=0, go to RUN.
  - RUN: per edge, if the multiplier LSB is 1, add the multiplicand to the accumulator upper half. Then shift {carry, accumulator} right 1 and increment `count`. After the edge where `count` reaches WIDTH-1, go to FIX.
  - FIX: load `{hi,lo}` with the accumulator, two's-complement negated over 2·WIDTH bits if `neg`=1. Go to IDLE.
- The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned; no overflow special case.
- Adder is WIDTH+1 bits; the carry is shifted into the accumulator MSB.
- Latency is fixed for all operands, including zero.
- `multstallD` = `hilouseD` & (`busy` | `multstartE`). It is combinational and the block's only combinational output.
- `multstartE` while busy is ignored. The operation in flight continues and HI/LO are not disturbed. The stall rule keeps this from happening in legal code.
- HI/LO hold their values between multiplies and are written only in FIX.

## Timing
- Reset values:
  - `hi`=0, `lo`=0, `done`=0, state IDLE, `busy`=0, `count`=0, `neg`=0.
  - `multstallD` follows its inputs.
- Edge E0: start accepted.
- Edges E1..E32: RUN iterations. `busy`=1 from after E0 until E33.
- Edge E33: FIX writes HI/LO and the state returns to IDLE.
- After E33: `done`=1 for exactly one cycle; new HI/LO are visible and `busy`=0.
- Back-to-back: a new start may be accepted at E34, the first IDLE edge.
- A consumer in Decode stalls through the cycle ending at E33 and proceeds in the following cycle, reading the new HI/LO.
- Reset during RUN or FIX:
  - The in-flight product is discarded.
  - At the next edge: state IDLE, `hi`=`lo`=0, `done`=0.
  - A `multstartE` coincident with reset is ignored.

## Test plan
- Unsigned max: `multsgnE`=0, a=b=0xFFFFFFFF.
  - `done` 34 cycles after the start edge.
  - hi=0xFFFFFFFE, lo=0x00000001; `busy` low after E33.
- Signed mixed: a=-3 (0xFFFFFFFD), b=5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Repeat with `multsgnE`=0: hi=0x00000004, lo=0xFFFFFFF1.
- Signed corner: a=b=0x80000000 gives hi=0x40000000, lo=0.
  - Then a=-1, b=-1 back-to-back at E34: hi=0, lo=1.
- Stall handshake: assert `hilouseD` from the start cycle on.
  - `multstallD`=1 in the start cycle and through E33, 0 after.
  - With `hilouseD`=0 during busy: `multstallD`=0.
- Start while busy: a second `multstartE` with a=2, b=2 at E10 is ignored.
  - The first product (7×6: hi=0, lo=42) completes at E33.
  - No second `done` pulse.
- Reset mid-op: assert `reset` at E15 of a multiply whose prior HI/LO were nonzero.
  - Next cycle: hi=lo=0, `busy`=0, no `done` pulse.
  - A fresh 7×6 then yields lo=42.
